// File: rtl/wb_regfile_stage_pkg.sv
// Shared encodings for the write-back stage: MemtoReg selects, MEM/WB bundle
// bit positions and architectural register indices.
package wb_regfile_stage_pkg;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  localparam int WB_REGWRITE = 2;
  localparam int WB_MTR_HI   = 1;
  localparam int WB_MTR_LO   = 0;

  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;

  localparam int NUM_RD = 2;

endpackage

// File: rtl/wb_regfile_stage_gpr_file_2r1w.sv
// 32-entry general-purpose register storage: one write port, NUM_RD
// combinational read ports with write-through bypass, $gp/$sp reset values.
module gpr_file_2r1w
  import wb_regfile_stage_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                RD_PORTS = NUM_RD,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h7FFF_EFFC,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h1000_8000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              we,
  input  logic [ADDR_W-1:0]                 wAddr,
  input  logic [DATA_W-1:0]                 wData,
  input  logic [RD_PORTS-1:0][ADDR_W-1:0]   rAddr,
  output logic [RD_PORTS-1:0][DATA_W-1:0]   rData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;

  function automatic logic [DATA_W-1:0] initVal(input int idx);
    if (idx == REG_GP) return GP_INIT;
    if (idx == REG_SP) return SP_INIT;
    return '0;
  endfunction

  // Entry 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= initVal(i);
    end else if (we && (wAddr != ADDR_W'(REG_ZERO))) begin
      regs[wAddr] <= wData;
    end
  end

  // Each port bypasses independently so ID sees the value committing this cycle.
  for (genvar p = 0; p < RD_PORTS; p++) begin : gRd
    assign rData[p] = (rAddr[p] == ADDR_W'(REG_ZERO)) ? '0 :
                      (we && (rAddr[p] == wAddr))     ? wData :
                                                        regs[rAddr[p]];
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects the MEM/WB result, commits it to the GPR file,
// exposes a one-cycle-delayed copy for EX forwarding and counts retired writes.
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h7FFF_EFFC,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h1000_8000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        wb_ctrl,
  input  logic [DATA_W-1:0] read_data_wb,
  input  logic [DATA_W-1:0] alu_res_wb,
  input  logic [ADDR_W-1:0] write_reg_wb,
  input  logic [DATA_W-1:0] pc2_wb,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retire_cnt
);

  logic                            regWrite;
  logic [1:0]                      memtoReg;
  logic [NUM_RD-1:0][DATA_W-1:0]   rdBus;

  assign regWrite = wb_ctrl[WB_REGWRITE];
  assign memtoReg = wb_ctrl[WB_MTR_HI:WB_MTR_LO];

  // Only the selected source reaches wb_data, so X on an idle input is masked.
  always_comb begin
    wb_data = alu_res_wb;
    case (memtoReg)
      MTR_MEM: wb_data = read_data_wb;
      MTR_PC:  wb_data = pc2_wb;
      default: wb_data = alu_res_wb;
    endcase
  end

  assign wb_we = regWrite && (write_reg_wb != ADDR_W'(REG_ZERO));

  gpr_file_2r1w #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RD_PORTS(NUM_RD),
    .SP_INIT (SP_INIT),
    .GP_INIT (GP_INIT)
  ) uGpr (
    .clk  (clk),
    .reset(reset),
    .we   (wb_we),
    .wAddr(write_reg_wb),
    .wData(wb_data),
    .rAddr({rt_addr, rs_addr}),
    .rData(rdBus)
  );

  assign rs_data = rdBus[0];
  assign rt_data = rdBus[1];

  // Stage is never stalled: forward copy and counter advance every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_valid  <= 1'b0;
      fwd_reg    <= '0;
      fwd_data   <= '0;
      retire_cnt <= '0;
    end else begin
      fwd_valid <= wb_we;
      fwd_reg   <= write_reg_wb;
      fwd_data  <= wb_data;
      if (wb_we) retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Scoreboarded bench for wb_regfile_stage: expected forward-register contents
// are queued at drive time and popped after the commit edge.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  wb_ctrl;
  logic [31:0] read_data_wb, alu_res_wb, pc2_wb;
  logic [4:0]  write_reg_wb, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_data, fwd_data, retire_cnt;
  logic        wb_we, fwd_valid;
  logic [4:0]  fwd_reg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
  } fwdExp_t;

  fwdExp_t     fwdQ[$];
  logic [31:0] expReg[32];
  logic [31:0] expCnt;

  localparam logic [31:0] GP = 32'h1000_8000;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;

  wb_regfile_stage dut (
    .clk(clk), .reset(reset), .wb_ctrl(wb_ctrl),
    .read_data_wb(read_data_wb), .alu_res_wb(alu_res_wb),
    .write_reg_wb(write_reg_wb), .pc2_wb(pc2_wb),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_we(wb_we),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] expWb(input logic [2:0] c,
                                        input logic [31:0] a, m, p);
    if (c[1:0] == 2'b01) return m;
    if (c[1:0] == 2'b10) return p;
    return a;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] a, input logic we,
                                          input logic [4:0] wr, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && a == wr) return wd;
    return expReg[a];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) expReg[i] = 32'd0;
    expReg[28] = GP;
    expReg[29] = SP;
    expCnt = 32'd0;
    fwdQ.delete();
  endtask

  // One pipeline cycle: drive at negedge, check combinational outputs, then
  // check the committed state after the rising edge.
  task automatic drive(input logic [2:0] ctrl, input logic [4:0] wr,
                       input logic [31:0] alu, mem, pc2,
                       input logic [4:0] ra, rb);
    logic        we;
    logic [31:0] wd, ers, ert;
    fwdExp_t     e;
    @(negedge clk);
    wb_ctrl = ctrl; write_reg_wb = wr;
    alu_res_wb = alu; read_data_wb = mem; pc2_wb = pc2;
    rs_addr = ra; rt_addr = rb;
    wd = expWb(ctrl, alu, mem, pc2);
    we = ctrl[2] && (wr != 5'd0);
    e.v = we; e.r = wr; e.d = wd;
    fwdQ.push_back(e);
    ers = expRead(ra, we, wr, wd);
    ert = expRead(rb, we, wr, wd);
    #1;
    checks++;
    if (wb_we !== we) begin errors++; $display("FAIL wb_we: got %b exp %b", wb_we, we); end
    checks++;
    if (wb_data !== wd) begin errors++; $display("FAIL wb_data: got %h exp %h", wb_data, wd); end
    checks++;
    if (rs_data !== ers) begin errors++; $display("FAIL rs_data[%0d]: got %h exp %h", ra, rs_data, ers); end
    checks++;
    if (rt_data !== ert) begin errors++; $display("FAIL rt_data[%0d]: got %h exp %h", rb, rt_data, ert); end
    @(posedge clk);
    #1;
    if (we) begin expReg[wr] = wd; expCnt = expCnt + 32'd1; end
    e = fwdQ.pop_front();
    checks++;
    if (fwd_valid !== e.v) begin errors++; $display("FAIL fwd_valid: got %b exp %b", fwd_valid, e.v); end
    checks++;
    if (fwd_reg !== e.r) begin errors++; $display("FAIL fwd_reg: got %0d exp %0d", fwd_reg, e.r); end
    checks++;
    if (fwd_data !== e.d) begin errors++; $display("FAIL fwd_data: got %h exp %h", fwd_data, e.d); end
    checks++;
    if (retire_cnt !== expCnt) begin errors++; $display("FAIL retire_cnt: got %0d exp %0d", retire_cnt, expCnt); end
  endtask

  task automatic readRegs(input logic [4:0] a, input logic [4:0] b);
    drive(3'b000, 5'd0, 32'd0, 32'd0, 32'd0, a, b);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wb_ctrl = 3'b000; write_reg_wb = 5'd0;
    alu_res_wb = 32'd0; read_data_wb = 32'd0; pc2_wb = 32'd0;
    rs_addr = 5'd29; rt_addr = 5'd28;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rs_data !== SP) begin errors++; $display("FAIL reset_sp_in_reset: got %h exp %h", rs_data, SP); end
    checks++;
    if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid: got %b exp 0", fwd_valid); end
    checks++;
    if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire_cnt: got %0d exp 0", retire_cnt); end
    @(negedge clk);
    reset = 1'b1;
    readRegs(5'd0, 5'd5);
    readRegs(5'd28, 5'd29);
  endtask

  task automatic test_memtoreg();
    drive(3'b100, 5'd8, 32'h0000_00AA, 32'h1111_1111, 32'h2222_2222, 5'd8, 5'd0);
    readRegs(5'd8, 5'd8);
    drive(3'b101, 5'd8, 32'h3333_3333, 32'hDEAD_BEEF, 32'h4444_4444, 5'd0, 5'd8);
    readRegs(5'd8, 5'd8);
    drive(3'b110, 5'd8, 32'h5555_5555, 32'h6666_6666, 32'h0040_0010, 5'd8, 5'd8);
    readRegs(5'd8, 5'd8);
    drive(3'b111, 5'd7, 32'h0BAD_F00D, 32'h7777_7777, 32'h8888_8888, 5'd7, 5'd8);
    readRegs(5'd7, 5'd8);
    checks++;
    if (retire_cnt !== 32'd4) begin errors++; $display("FAIL mtr_count: got %0d exp 4", retire_cnt); end
  endtask

  task automatic test_bypass();
    drive(3'b100, 5'd9, 32'd1, 32'd0, 32'd0, 5'd0, 5'd0);
    drive(3'b100, 5'd9, 32'h1234_5678, 32'd0, 32'd0, 5'd9, 5'd9);
    drive(3'b101, 5'd11, 32'd0, 32'hCAFE_0001, 32'd0, 5'd9, 5'd11);
    readRegs(5'd9, 5'd11);
  endtask

  task automatic test_reg_zero();
    drive(3'b100, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd0);
    readRegs(5'd0, 5'd0);
  endtask

  task automatic test_no_regwrite();
    drive(3'b001, 5'd10, 32'd0, 32'h5555_5555, 32'd0, 5'd10, 5'd10);
    readRegs(5'd10, 5'd10);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++)
      drive(3'b100, (i % 2 == 0) ? 5'd1 : 5'd2, 32'hA000_0000 + i, 32'd0, 32'd0, 5'd1, 5'd2);
    @(negedge clk);
    wb_ctrl = 3'b100; write_reg_wb = 5'd2; alu_res_wb = 32'h0000_AAAA;
    rs_addr = 5'd1; rt_addr = 5'd28;
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checks++;
    if (rs_data !== 32'd0) begin errors++; $display("FAIL async_rs_reg1: got %h exp 0", rs_data); end
    checks++;
    if (rt_data !== GP) begin errors++; $display("FAIL async_rt_gp: got %h exp %h", rt_data, GP); end
    checks++;
    if (fwd_valid !== 1'b0 || fwd_reg !== 5'd0 || fwd_data !== 32'd0) begin
      errors++; $display("FAIL async_fwd: got %b/%0d/%h exp 0/0/0", fwd_valid, fwd_reg, fwd_data);
    end
    checks++;
    if (retire_cnt !== 32'd0) begin errors++; $display("FAIL async_cnt: got %0d exp 0", retire_cnt); end
    checks++;
    if (wb_we !== 1'b1 || wb_data !== 32'h0000_AAAA) begin
      errors++; $display("FAIL async_comb: got %b/%h exp 1/0000aaaa", wb_we, wb_data);
    end
    @(posedge clk);
    #1;
    wb_ctrl = 3'b000; rs_addr = 5'd2;
    #1;
    checks++;
    if (rs_data !== 32'd0) begin errors++; $display("FAIL async_write_lost: got %h exp 0", rs_data); end
    checks++;
    if (retire_cnt !== 32'd0) begin errors++; $display("FAIL async_cnt_held: got %0d exp 0", retire_cnt); end
    @(negedge clk);
    reset = 1'b1;
    drive(3'b100, 5'd3, 32'h0000_0033, 32'd0, 32'd0, 5'd1, 5'd2);
  endtask

  task automatic test_wrap();
    dut.retire_cnt = 32'hFFFF_FFFF;
    expCnt = 32'hFFFF_FFFF;
    drive(3'b100, 5'd4, 32'h0000_0044, 32'd0, 32'd0, 5'd4, 5'd3);
    checks++;
    if (retire_cnt !== 32'd0) begin errors++; $display("FAIL wrap: got %h exp 0", retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_memtoreg();
    test_bypass();
    test_reg_zero();
    test_no_regwrite();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Write-back end of the pipeline: consumes the MEM/WB register outputs, selects the write-back value, and commits it to a 32x32 general-purpose register file.
- Serves the ID stage with two combinational read ports that include same-cycle write-through bypass.
- Keeps a one-cycle-delayed copy of the last committed write for the EX forwarding unit.
- Counts retired register writes for debug.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (32 registers)
- SP_INIT, 32'h7FFF_EFFC, reset value of register 29 ($sp)
- GP_INIT, 32'h1000_8000, reset value of register 28 ($gp)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wb_ctrl  in  3  MEM/WB control bundle: [2]=RegWrite, [1:0]=MemtoReg
- read_data_wb  in  32  data-memory read data from MEM/WB
- alu_res_wb  in  32  ALU result from MEM/WB
- write_reg_wb  in  5  destination register index from MEM/WB
- pc2_wb  in  32  PC+4 link value from MEM/WB
- rs_addr  in  5  ID read port A index
- rt_addr  in  5  ID read port B index
- rs_data  out  32  read port A data
- rt_data  out  32  read port B data
- wb_data  out  32  selected write-back value, combinational, current cycle
- wb_we  out  1  effective write enable, combinational, current cycle
- fwd_valid  out  1  registered: a write was committed last cycle
- fwd_reg  out  5  registered: index of that write
- fwd_data  out  32  registered: value of that write
- retire_cnt  out  32  count of committed writes

Behaviour:
- MemtoReg select for wb_data:
  - 00 = alu_res_wb
  - 01 = read_data_wb
  - 10 = pc2_wb (jal link)
  - 11 = alu_res_wb (reserved, defined fallback)
- wb_we = RegWrite AND (write_reg_wb != 0). Writes to register 0 are discarded everywhere: no storage update, no bypass, no fwd_valid, no count.
- Commit: on a rising clk edge with wb_we=1, regs[write_reg_wb] <= wb_data. Latency 1 cycle to storage.
- Read ports are combinational:
  - addr==0 returns 0.
  - If wb_we=1 and addr==write_reg_wb, the port returns wb_data (write-before-read bypass).
  - Otherwise the port returns the stored value.
  - Both ports bypass independently; rs_addr==rt_addr==write_reg_wb returns wb_data on both.
- Forward register: each rising edge, fwd_valid <= wb_we, fwd_reg <= write_reg_wb, fwd_data <= wb_data. The fwd_reg and fwd_data values are captured unconditionally; they are only meaningful when fwd_valid=1.
- retire_cnt increments by 1 on each edge with wb_we=1. It wraps from 32'hFFFF_FFFF to 0 with no saturation.
- Reset (reset=0, asynchronous, at any time including mid-write):
  - All registers become 0, except reg 28 = GP_INIT and reg 29 = SP_INIT.
  - fwd_valid, fwd_reg, fwd_data become 0; retire_cnt becomes 0.
  - A write presented in the reset cycle is lost.
  - Combinational outputs (rs_data, rt_data, wb_data, wb_we) follow inputs and reset storage.
- First rising edge after reset deasserts behaves normally. No internal enable exists: the stage is never stalled, matching the free-running MEM/WB register.
- X on an unused data input, when not selected by MemtoReg, must not propagate to wb_data.

Decomposition:
- Shared package holds:
  - MemtoReg encodings: MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_PC=2'b10.
  - WB bundle bit positions: WB_REGWRITE=2, WB_MTR_HI=1, WB_MTR_LO=0.
  - Register index constants: REG_ZERO=0, REG_GP=28, REG_SP=29.
- One sub-module: gpr_file_2r1w, the 32-entry storage with two bypassed read ports and reset initialisation.
- The mux, forward register and counter live in the top.

Test Plan:
- Reset: hold reset=0, then release; read regs 0, 5, 28, 29 -> 0, 0, 32'h1000_8000, 32'h7FFF_EFFC. fwd_valid=0, retire_cnt=0.
- MemtoReg select, reg 8, one cycle each:
  - wb_ctrl=3'b100, alu=32'h0000_00AA -> reg 8 = 32'h0000_00AA.
  - wb_ctrl=3'b101, mem=32'hDEAD_BEEF -> reg 8 = 32'hDEAD_BEEF.
  - wb_ctrl=3'b110, pc2=32'h0040_0010 -> reg 8 = 32'h0040_0010.
  - Expected retire_cnt = 3.
- Bypass: with reg 9 holding 1, drive a write of 32'h1234_5678 to reg 9 and rs_addr=rt_addr=9 in the same cycle -> rs_data=rt_data=32'h1234_5678 before the edge. Next cycle fwd_valid=1, fwd_reg=9, fwd_data=32'h1234_5678.
- Register 0: wb_ctrl=3'b100, write_reg=0, alu=32'hFFFF_FFFF -> wb_we=0, rs_data for addr 0 stays 0, fwd_valid=0 next cycle, retire_cnt unchanged.
- RegWrite low: wb_ctrl=3'b001, write_reg=10, mem=32'h5555_5555 -> reg 10 unchanged, no count.
- Asynchronous reset mid-stream: alternate writes to regs 1 and 2 every cycle, then pulse reset low between clock edges -> all outputs and storage return to reset values immediately, without waiting for a clock edge. Counter wrap: force retire_cnt to 32'hFFFF_FFFF via hierarchical deposit, then commit one write -> retire_cnt = 0.
